// File: rtl/load_store_unit.sv
// Memory-stage load/store bridge to a word-wide dmem: decodes funct3, checks alignment,
// performs read-modify-write for sub-word stores and formats/extends load data.
module load_store_unit #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] load_r;
    logic        we_r;
    logic        err_r;
    logic [2:0]  funct3_r;
    logic [2:0]  cnt_r;
    logic        accept_s;
    logic        rd_done_s;

    // Illegal encodings, stores with an unsigned funct3 and misaligned H/W accesses.
    function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic e;
        case (f3)
            3'b000:         e = 1'b0;
            3'b100:         e = 1'b0;
            3'b001, 3'b101: e = a[0];
            3'b010:         e = (a != 2'b00);
            default:        e = 1'b1;
        endcase
        if (we && f3[2]) begin
            e = 1'b1;
        end else begin
            e = e;
        end
        return e;
    endfunction

    function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] w;
        w = old;
        case (f3[1:0])
            2'b00: begin
                case (a)
                    2'b00:   w[7:0]   = wd[7:0];
                    2'b01:   w[15:8]  = wd[7:0];
                    2'b10:   w[23:16] = wd[7:0];
                    2'b11:   w[31:24] = wd[7:0];
                    default: w = old;
                endcase
            end
            2'b01: begin
                if (a[1]) begin
                    w[31:16] = wd[15:0];
                end else begin
                    w[15:0] = wd[15:0];
                end
            end
            default: w = wd;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {a, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b100:  r = {24'h000000, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    assign accept_s  = req_valid && (state_r == IDLE);
    assign rd_done_s = (state_r == RD) && (cnt_r == 3'(RD_LAT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_s = IDLE;
                end else if (req_error(req_we, req_funct3, req_addr[1:0])) begin
                    state_s = RESP;
                end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
                    state_s = WR;
                end else begin
                    state_s = RD;
                end
            end
            RD: begin
                if (!rd_done_s) begin
                    state_s = RD;
                end else if (we_r) begin
                    state_s = WR;
                end else begin
                    state_s = RESP;
                end
            end
            WR:      state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Request latches, read-cycle counter, merged store word and formatted load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            load_r   <= 32'h0000_0000;
            we_r     <= 1'b0;
            err_r    <= 1'b0;
            funct3_r <= 3'b000;
            cnt_r    <= 3'd0;
        end else if (accept_s) begin
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            load_r   <= 32'h0000_0000;
            we_r     <= req_we;
            err_r    <= req_error(req_we, req_funct3, req_addr[1:0]);
            funct3_r <= req_funct3;
            cnt_r    <= 3'd0;
        end else if (state_r == RD) begin
            cnt_r <= cnt_r + 3'd1;
            if (rd_done_s && we_r) begin
                wdata_r <= merge_store(funct3_r, addr_r[1:0], mem_rdata, wdata_r);
            end else if (rd_done_s) begin
                load_r <= format_load(funct3_r, addr_r[1:0], mem_rdata);
            end else begin
                load_r <= load_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Output decode from the state register and request latches.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0000_0000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'h0000_0000;
        mem_wdata  = 32'h0000_0000;
        case (state_r)
            IDLE: req_ready = 1'b1;
            RD: begin
                mem_read  = 1'b1;
                mem_addr  = {addr_r[31:2], 2'b00};
                mem_wdata = wdata_r;
            end
            WR: begin
                mem_write = 1'b1;
                mem_addr  = {addr_r[31:2], 2'b00};
                mem_wdata = wdata_r;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_r;
                resp_rdata = (we_r || err_r) ? 32'h0000_0000 : load_r;
            end
            default: req_ready = 1'b0;
        endcase
    end

endmodule
